// File: rtl/cmd_phy.sv
// cmd_phy: SD-host CMD-line PHY. It inserts CRC7 into a 48-bit command and serialises it, then optionally receives a 48-bit response.
// Build option: define CMD_PHY_RESP_CRC_CHECK_EN to check the CRC7 and end bit of the response.
`timescale 1ns/1ps
module cmd_phy #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NCR_MIN        = 2,
  parameter int TCNT_W         = 16
) (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iStrobe_in,
  input  logic [47:0] iCmd_frame,
  input  logic        iTimeout_enable,
  input  logic        iAck_in,
  output logic        oAck_out,
  output logic        oStrobe_out,
  output logic [47:0] oResponse,
  output logic        oTimeout,
  output logic        oCrc_error,
  output logic        oIdle,
  output logic        oCmd_serial,
  output logic        oCmd_oe,
  input  logic        iCmd_serial
);

  typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT_START, RECV, HANDOFF} phyStateT;

  phyStateT            state;
  phyStateT            stateNext;
  logic                strobePrev;
  logic                strobeRise;
  logic [47:0]         txShift;
  logic [6:0]          txCrc;
  logic [5:0]          bitCnt;
  logic                respExpected;
  logic [TCNT_W-1:0]   waitCnt;
  logic [46:0]         rxShift;
  logic [47:0]         response;
  logic                ackOut;
  logic                timeoutOut;
  logic                txCrcPhase;
  logic                unusedFrameBits;

  localparam logic [TCNT_W-1:0] TURN_LAST = TCNT_W'(NCR_MIN - 1);
  localparam logic [TCNT_W-1:0] WAIT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic bitIn);
    logic fb;
    fb = crc[6] ^ bitIn;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign strobeRise      = iStrobe_in && !strobePrev;
  assign unusedFrameBits = ^{iCmd_frame[47:46], iCmd_frame[0]};

  always_ff @(posedge iClock_host) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:       if (strobeRise) stateNext = SEND;
      SEND:       if (bitCnt == 6'd47) stateNext = respExpected ? TURN : IDLE;
      TURN:       if (waitCnt == TURN_LAST) stateNext = WAIT_START;
      // A start bit on the final counted cycle still beats the timeout.
      WAIT_START: if (!iCmd_serial) stateNext = RECV;
                  else if (waitCnt == WAIT_LAST) stateNext = IDLE;
      RECV:       if (bitCnt == 6'd46) stateNext = HANDOFF;
      HANDOFF:    if (iAck_in) stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

`ifdef CMD_PHY_RESP_CRC_CHECK_EN
  logic [6:0] rxCrc;
  logic       crcErr;
  assign oCrc_error = crcErr;
`else
  assign oCrc_error = 1'b0;
`endif

  always_ff @(posedge iClock_host) begin
    if (iReset) begin
      strobePrev   <= 1'b0;
      txShift      <= '0;
      txCrc        <= '0;
      bitCnt       <= '0;
      respExpected <= 1'b0;
      waitCnt      <= '0;
      rxShift      <= '0;
      response     <= '0;
      ackOut       <= 1'b0;
      timeoutOut   <= 1'b0;
`ifdef CMD_PHY_RESP_CRC_CHECK_EN
      rxCrc        <= '0;
      crcErr       <= 1'b0;
`endif
    end else begin
      strobePrev <= iStrobe_in;
      ackOut     <= 1'b0;
      timeoutOut <= 1'b0;
      case (state)
        IDLE: if (strobeRise) begin
          txShift      <= {2'b01, iCmd_frame[45:1], 1'b1};
          respExpected <= iTimeout_enable;
          ackOut       <= 1'b1;
          txCrc        <= '0;
          bitCnt       <= '0;
`ifdef CMD_PHY_RESP_CRC_CHECK_EN
          crcErr       <= 1'b0;
`endif
        end
        SEND: begin
          txShift <= {txShift[46:0], 1'b0};
          bitCnt  <= bitCnt + 6'd1;
          waitCnt <= '0;
          // Bits 7..1 on the wire come from the CRC register, shifted out MSB first.
          if (bitCnt < 6'd40) txCrc <= crc7Step(txCrc, txShift[47]);
          else                txCrc <= {txCrc[5:0], 1'b0};
        end
        TURN: waitCnt <= (waitCnt == TURN_LAST) ? '0 : waitCnt + TCNT_W'(1);
        WAIT_START: begin
          waitCnt <= waitCnt + TCNT_W'(1);
          if (!iCmd_serial) begin
            rxShift <= '0;
            bitCnt  <= '0;
`ifdef CMD_PHY_RESP_CRC_CHECK_EN
            rxCrc   <= '0;
`endif
          end else if (waitCnt == WAIT_LAST) begin
            timeoutOut <= 1'b1;
          end
        end
        RECV: begin
          rxShift <= {rxShift[45:0], iCmd_serial};
          bitCnt  <= bitCnt + 6'd1;
          if (bitCnt == 6'd46) response <= {rxShift, iCmd_serial};
`ifdef CMD_PHY_RESP_CRC_CHECK_EN
          if (bitCnt < 6'd39) rxCrc <= crc7Step(rxCrc, iCmd_serial);
          if (bitCnt == 6'd46) crcErr <= (rxCrc != rxShift[6:0]) || !iCmd_serial;
`endif
        end
        default: ;
      endcase
    end
  end

  assign txCrcPhase  = (bitCnt >= 6'd40) && (bitCnt <= 6'd46);
  assign oCmd_oe     = (state == SEND);
  assign oCmd_serial = (state != SEND) ? 1'b1 : (txCrcPhase ? txCrc[6] : txShift[47]);
  assign oIdle       = (state == IDLE);
  assign oStrobe_out = (state == HANDOFF);
  assign oAck_out    = ackOut;
  assign oTimeout    = timeoutOut;
  assign oResponse   = response;

endmodule

// File: tb/tb_cmd_phy.sv
// tb_cmd_phy: directed self-checking bench for cmd_phy (framing, CRC7 insertion, response path, timeout, reset).
`timescale 1ns/1ps
module tb_cmd_phy;
  localparam int NCR = 2;
  localparam int TMO = 64;
  localparam logic [47:0] CMD0      = 48'h400000000000;
  localparam logic [47:0] CMD0_WIRE = 48'h400000000095;
  localparam logic [47:0] CMD8_IN   = 48'h88000001AAFE;
  localparam logic [47:0] CMD8_WIRE = 48'h48000001AA87;
  localparam logic [47:0] R7        = 48'h08000001AA13;
  localparam logic [47:0] R7_BAD    = 48'h08000000AA13;
`ifdef CMD_PHY_RESP_CRC_CHECK_EN
  localparam logic [47:0] EXP_CRC_ERR = 48'h1;
`else
  localparam logic [47:0] EXP_CRC_ERR = 48'h0;
`endif

  logic        clk = 1'b0;
  logic        iReset, iStrobe_in, iTimeout_enable, iAck_in, iCmd_serial;
  logic [47:0] iCmd_frame;
  logic        oAck_out, oStrobe_out, oTimeout, oCrc_error, oIdle, oCmd_serial, oCmd_oe;
  logic [47:0] oResponse;

  cmd_phy #(.TIMEOUT_CYCLES(TMO), .NCR_MIN(NCR), .TCNT_W(16)) dut (
    .iClock_host(clk), .iReset(iReset), .iStrobe_in(iStrobe_in), .iCmd_frame(iCmd_frame),
    .iTimeout_enable(iTimeout_enable), .iAck_in(iAck_in), .oAck_out(oAck_out),
    .oStrobe_out(oStrobe_out), .oResponse(oResponse), .oTimeout(oTimeout),
    .oCrc_error(oCrc_error), .oIdle(oIdle), .oCmd_serial(oCmd_serial), .oCmd_oe(oCmd_oe),
    .iCmd_serial(iCmd_serial)
  );

  always #5 clk = ~clk;

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int exp);
    totalCnt++;
    assert (obs == exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe a frame in and capture the wire bits while the line is driven.
  task automatic doFrame(input logic [47:0] frame, input logic te, input logic hold,
                         output logic [47:0] bits, output int oeCycles, output int acks);
    iCmd_frame = frame; iTimeout_enable = te; iStrobe_in = 1'b1;
    step();
    if (!hold) iStrobe_in = 1'b0;
    bits = '0; oeCycles = 0; acks = 0;
    for (int i = 0; i < 60 && oCmd_oe; i++) begin
      bits = {bits[46:0], oCmd_serial};
      oeCycles++;
      acks += int'(oAck_out);
      step();
    end
  endtask

  task automatic driveResp(input logic [47:0] w, output int tmoSeen);
    tmoSeen = 0;
    for (int i = 47; i >= 0; i--) begin
      iCmd_serial = w[i];
      tmoSeen += int'(oTimeout);
      step();
    end
    iCmd_serial = 1'b1;
  endtask

  logic [47:0] bits;
  int oeC, acks, stb, tmo, n, oeX, ackX;

  initial begin
    iReset = 1'b1; iStrobe_in = 1'b0; iTimeout_enable = 1'b0; iAck_in = 1'b0;
    iCmd_serial = 1'b1; iCmd_frame = '0;
    step(); step();
    chk("rst_idle", 48'(oIdle), 48'h1);
    chk("rst_oe", 48'(oCmd_oe), 48'h0);
    chk("rst_serial", 48'(oCmd_serial), 48'h1);
    chk("rst_ack", 48'(oAck_out), 48'h0);
    chk("rst_strobe", 48'(oStrobe_out), 48'h0);
    chk("rst_timeout", 48'(oTimeout), 48'h0);
    chk("rst_crcerr", 48'(oCrc_error), 48'h0);
    chk("rst_resp", oResponse, 48'h0);
    iReset = 1'b0;
    step();

    doFrame(CMD0, 1'b0, 1'b0, bits, oeC, acks);
    $display("CMD0 wire=%h oe_cycles=%0d acks=%0d", bits, oeC, acks);
    chk("cmd0_bits", bits, CMD0_WIRE);
    chkInt("cmd0_oe_cycles", oeC, 48);
    chkInt("cmd0_acks", acks, 1);
    chk("cmd0_idle", 48'(oIdle), 48'h1);
    stb = 0; tmo = 0;
    for (int i = 0; i < 80; i++) begin
      stb += int'(oStrobe_out); tmo += int'(oTimeout); step();
    end
    chkInt("cmd0_no_strobe", stb, 0);
    chkInt("cmd0_no_timeout", tmo, 0);

    doFrame(CMD0, 1'b0, 1'b1, bits, oeC, acks);
    oeX = 0; ackX = 0;
    for (int i = 0; i < 100; i++) begin
      oeX += int'(oCmd_oe); ackX += int'(oAck_out); step();
    end
    $display("HELD strobe wire=%h oe_cycles=%0d acks=%0d", bits, oeC + oeX, acks + ackX);
    chk("held_bits", bits, CMD0_WIRE);
    chkInt("held_acks", acks + ackX, 1);
    chkInt("held_oe_cycles", oeC + oeX, 48);
    iStrobe_in = 1'b0;
    step();

    doFrame(CMD8_IN, 1'b1, 1'b0, bits, oeC, acks);
    chk("cmd8_bits", bits, CMD8_WIRE);
    repeat (5) step();
    driveResp(R7, tmo);
    $display("CMD8 wire=%h resp=%h strobe=%0b crcerr=%0b", bits, oResponse, oStrobe_out, oCrc_error);
    chk("cmd8_strobe", 48'(oStrobe_out), 48'h1);
    chk("cmd8_resp", oResponse, R7);
    chk("cmd8_crcerr", 48'(oCrc_error), 48'h0);
    chkInt("cmd8_no_timeout", tmo, 0);
    stb = 0;
    for (int i = 0; i < 3; i++) begin
      stb += int'(oStrobe_out); step();
    end
    chkInt("cmd8_strobe_hold", stb, 3);
    iAck_in = 1'b1; step(); iAck_in = 1'b0;
    chk("cmd8_strobe_fall", 48'(oStrobe_out), 48'h0);
    chk("cmd8_idle", 48'(oIdle), 48'h1);

    doFrame(CMD8_IN, 1'b1, 1'b0, bits, oeC, acks);
    n = 0; stb = 0;
    while (!oTimeout && n < 200) begin
      stb += int'(oStrobe_out); step(); n++;
    end
    $display("TIMEOUT after %0d cycles from line release", n);
    chkInt("tmo_latency", n, NCR + TMO);
    chk("tmo_pulse", 48'(oTimeout), 48'h1);
    step();
    chk("tmo_pulse_end", 48'(oTimeout), 48'h0);
    chk("tmo_idle", 48'(oIdle), 48'h1);
    chkInt("tmo_no_strobe", stb, 0);

    doFrame(CMD8_IN, 1'b1, 1'b0, bits, oeC, acks);
    repeat (NCR + TMO - 1) step();
    driveResp(R7, tmo);
    $display("LATE start bit resp=%h strobe=%0b timeouts=%0d", oResponse, oStrobe_out, tmo);
    chkInt("late_no_timeout", tmo, 0);
    chk("late_strobe", 48'(oStrobe_out), 48'h1);
    chk("late_resp", oResponse, R7);
    iAck_in = 1'b1; step(); iAck_in = 1'b0;

    doFrame(CMD8_IN, 1'b1, 1'b0, bits, oeC, acks);
    repeat (5) step();
    driveResp(R7_BAD, tmo);
    $display("BAD resp=%h strobe=%0b crcerr=%0b", oResponse, oStrobe_out, oCrc_error);
    chk("bad_strobe", 48'(oStrobe_out), 48'h1);
    chk("bad_resp", oResponse, R7_BAD);
    chk("bad_crcerr", 48'(oCrc_error), EXP_CRC_ERR);
    iStrobe_in = 1'b1; step(); iStrobe_in = 1'b0;
    chk("handoff_strobe_ignored", 48'(oAck_out), 48'h0);
    iAck_in = 1'b1; step(); iAck_in = 1'b0;
    oeX = 0;
    for (int i = 0; i < 20; i++) begin
      oeX += int'(oCmd_oe); step();
    end
    chkInt("strobe_not_queued", oeX, 0);
    doFrame(CMD0, 1'b0, 1'b0, bits, oeC, acks);
    chk("crcerr_cleared", 48'(oCrc_error), 48'h0);
    chk("after_bad_bits", bits, CMD0_WIRE);

    iCmd_frame = CMD0; iTimeout_enable = 1'b0; iStrobe_in = 1'b1;
    step();
    iStrobe_in = 1'b0;
    repeat (30) step();
    chk("midsend_oe", 48'(oCmd_oe), 48'h1);
    iReset = 1'b1; step();
    $display("RESET mid-send oe=%0b serial=%0b idle=%0b", oCmd_oe, oCmd_serial, oIdle);
    chk("midrst_oe", 48'(oCmd_oe), 48'h0);
    chk("midrst_serial", 48'(oCmd_serial), 48'h1);
    chk("midrst_idle", 48'(oIdle), 48'h1);
    iReset = 1'b0; step();
    doFrame(CMD0, 1'b0, 1'b0, bits, oeC, acks);
    chk("postrst_bits", bits, CMD0_WIRE);
    chkInt("postrst_acks", acks, 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
